// File: rtl/trap_ctrl_if.sv
// Commit-stage / trap-controller bus: retire info and CSR access from the
// pipeline, redirect, flush and interrupt acknowledge back to it.
interface trap_ctrl_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_IRQ = 4
);
    logic [NUM_IRQ-1:0] irq_i;
    logic               retire_valid;
    logic [XLEN-1:0]    retire_pc;
    logic [1:0]         exc_cause;
    logic               mret;
    logic               csr_we;
    logic [11:0]        csr_addr;
    logic [XLEN-1:0]    csr_wdata;
    logic [XLEN-1:0]    csr_rdata;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               flush;
    logic [NUM_IRQ-1:0] irq_ack;

    // Pipeline / commit-stage side
    modport master (
        output irq_i, retire_valid, retire_pc, exc_cause, mret,
               csr_we, csr_addr, csr_wdata,
        input  csr_rdata, redirect_valid, redirect_pc, flush, irq_ack
    );

    // Trap controller side
    modport slave (
        input  irq_i, retire_valid, retire_pc, exc_cause, mret,
               csr_we, csr_addr, csr_wdata,
        output csr_rdata, redirect_valid, redirect_pc, flush, irq_ack
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: M-mode trap CSRs, prioritised external
// interrupts and synchronous exceptions arbitrated at retire, a one-cycle
// redirect/flush, then a fixed drain window before the next commit is seen.
module trap_ctrl #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     NUM_IRQ      = 4,
    parameter int unsigned     DRAIN_CYCLES = 2,
    parameter logic [XLEN-1:0] MTVEC_RESET  = '0,
    parameter bit              VECTORED_EN  = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    trap_ctrl_if.slave    bus
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    // mepc is word aligned; mtvec bit1 is a hard-wired zero of MODE
    localparam logic [XLEN-1:0] PC_MASK    = ~XLEN'(3);
    localparam logic [XLEN-1:0] MTVEC_MASK = ~XLEN'(2);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        RUN,
        REDIRECT,
        DRAIN
    } state_t;

    state_t             stateQ;
    state_t             stateD;
    logic [3:0]         drainCnt;
    logic [XLEN-1:0]    targetQ;

    logic [NUM_IRQ-1:0] irqPrev;
    logic [NUM_IRQ-1:0] pend;

    logic               mstatusMie;
    logic               mstatusMpie;
    logic [NUM_IRQ-1:0] mieReg;
    logic [XLEN-1:0]    mtvecQ;
    logic [XLEN-1:0]    mepcQ;
    logic [XLEN-1:0]    mcauseQ;

    logic [NUM_IRQ-1:0] irqMasked;
    logic [3:0]         irqIdx;
    logic               irqFound;
    logic               commitValid;
    logic               excTaken;
    logic               irqTaken;
    logic               mretTaken;
    logic               csrWrite;
    logic [XLEN-1:0]    irqCode;
    logic [XLEN-1:0]    trapBase;
    logic [XLEN-1:0]    trapTarget;
    logic [NUM_IRQ-1:0] ackOneHot;

    // Retire-boundary arbitration: exception > interrupt > mret > CSR write
    always_comb begin
        irqMasked = pend & mieReg;
        irqIdx    = '0;
        irqFound  = 1'b0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (irqMasked[i] && !irqFound) begin
                irqIdx   = 4'(i);
                irqFound = 1'b1;
            end
        end

        commitValid = (stateQ == RUN) && bus.retire_valid;
        excTaken    = commitValid && (bus.exc_cause != 2'b00);
        irqTaken    = commitValid && !excTaken && mstatusMie && irqFound;
        mretTaken   = commitValid && !excTaken && !irqTaken && bus.mret;
        csrWrite    = commitValid && !excTaken && !irqTaken && !mretTaken && bus.csr_we;

        irqCode  = XLEN'(16) + XLEN'(irqIdx);
        trapBase = {mtvecQ[XLEN-1:2], 2'b00};

        trapTarget = trapBase;
        if (irqTaken && VECTORED_EN && mtvecQ[0]) begin
            trapTarget = trapBase + (irqCode << 2);
        end else if (mretTaken) begin
            trapTarget = mepcQ;
        end

        ackOneHot = '0;
        if (irqTaken) begin
            ackOneHot = {{(NUM_IRQ-1){1'b0}}, 1'b1} << irqIdx;
        end
    end

    // Next-state and datapath-facing outputs
    always_comb begin
        stateD             = stateQ;
        bus.redirect_valid = 1'b0;
        bus.flush          = 1'b0;
        bus.redirect_pc    = '0;
        bus.irq_ack        = ackOneHot;
        case (stateQ)
            RUN: begin
                if (excTaken || irqTaken || mretTaken) begin
                    stateD = REDIRECT;
                end
            end
            REDIRECT: begin
                bus.redirect_valid = 1'b1;
                bus.flush          = 1'b1;
                bus.redirect_pc    = targetQ;
                stateD             = DRAIN;
            end
            DRAIN: begin
                if (drainCnt <= 4'd1) begin
                    stateD = RUN;
                end
            end
            default: stateD = RUN;
        endcase
    end

    // State register, latched redirect target and drain counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ   <= RUN;
            drainCnt <= '0;
            targetQ  <= '0;
        end else begin
            stateQ <= stateD;
            if (stateQ == RUN && (excTaken || irqTaken || mretTaken)) begin
                targetQ <= trapTarget;
            end
            if (stateQ == REDIRECT) begin
                drainCnt <= DRAIN_LOAD;
            end else if (stateQ == DRAIN) begin
                drainCnt <= drainCnt - 4'd1;
            end
        end
    end

    // Rising-edge interrupt capture; a new edge beats a same-cycle acknowledge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irqPrev <= '0;
            pend    <= '0;
        end else begin
            irqPrev <= bus.irq_i;
            pend    <= (pend & ~ackOneHot) | (bus.irq_i & ~irqPrev);
        end
    end

    // Trap CSRs: trap/mret side effects take precedence over a software write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatusMie  <= 1'b0;
            mstatusMpie <= 1'b0;
            mieReg      <= '0;
            mtvecQ      <= MTVEC_RESET & MTVEC_MASK;
            mepcQ       <= '0;
            mcauseQ     <= '0;
        end else if (excTaken) begin
            mepcQ       <= bus.retire_pc & PC_MASK;
            mcauseQ     <= (bus.exc_cause == 2'b10) ? XLEN'(11) : XLEN'(2);
            mstatusMpie <= mstatusMie;
            mstatusMie  <= 1'b0;
        end else if (irqTaken) begin
            mepcQ       <= bus.retire_pc & PC_MASK;
            mcauseQ     <= {1'b1, irqCode[XLEN-2:0]};
            mstatusMpie <= mstatusMie;
            mstatusMie  <= 1'b0;
        end else if (mretTaken) begin
            mstatusMie  <= mstatusMpie;
            mstatusMpie <= 1'b1;
        end else if (csrWrite) begin
            case (bus.csr_addr)
                CSR_MSTATUS: begin
                    mstatusMie  <= bus.csr_wdata[3];
                    mstatusMpie <= bus.csr_wdata[7];
                end
                CSR_MIE:    mieReg  <= bus.csr_wdata[NUM_IRQ-1:0];
                CSR_MTVEC:  mtvecQ  <= bus.csr_wdata & MTVEC_MASK;
                CSR_MEPC:   mepcQ   <= bus.csr_wdata & PC_MASK;
                CSR_MCAUSE: mcauseQ <= bus.csr_wdata;
                default: ;
            endcase
        end
    end

    // Combinational CSR read of the registered state
    always_comb begin
        bus.csr_rdata = '0;
        case (bus.csr_addr)
            CSR_MSTATUS: begin
                bus.csr_rdata[3] = mstatusMie;
                bus.csr_rdata[7] = mstatusMpie;
            end
            CSR_MIE:    bus.csr_rdata[NUM_IRQ-1:0] = mieReg;
            CSR_MTVEC:  bus.csr_rdata = mtvecQ;
            CSR_MEPC:   bus.csr_rdata = mepcQ;
            CSR_MCAUSE: bus.csr_rdata = mcauseQ;
            CSR_MIP:    bus.csr_rdata[NUM_IRQ-1:0] = pend;
            default: ;
        endcase
    end

endmodule
